// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module   : adder_share_arbiter
// Purpose  : Round-robin sharing of one WIDTH-bit adder among NREQ requesters,
//            with a back-pressurable registered result channel.
// Option   : define ADDER_SAT_EN to saturate res_data on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [WIDTH-1:0]        res_data,
   output logic                    res_carry,
   output logic [IDW-1:0]          res_id
);

   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q,  res_data_d;
   logic             res_carry_q, res_carry_d;
   logic [IDW-1:0]   res_id_q,    res_id_d;
   logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;

   logic             can_accept;
   logic             any_valid;
   logic             xfer;
   logic [IDW-1:0]   sel;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sum_data;

   // Grant: lowest valid index at or above rr_ptr, else lowest valid index overall.
   always_comb begin
      can_accept = !res_valid_q || res_ready;
      any_valid  = 1'b0;
      sel        = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            any_valid = 1'b1;
            sel       = IDW'(i);
         end
      end
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i] && (i >= int'(rr_ptr_q))) begin
            sel = IDW'(i);
         end
      end
      xfer      = can_accept && any_valid && !rst;
      req_ready = xfer ? (NREQ'(1) << sel) : '0;
   end

   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel == IDW'(i)) begin
            op_a = req_a[i*WIDTH +: WIDTH];
            op_b = req_b[i*WIDTH +: WIDTH];
         end
      end
      sum = {1'b0, op_a} + {1'b0, op_b};
`ifdef ADDER_SAT_EN
      sum_data = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
      sum_data = sum[WIDTH-1:0];
`endif
   end

   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_carry_d = res_carry_q;
      res_id_d    = res_id_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         res_valid_d = 1'b1;
         res_data_d  = sum_data;
         res_carry_d = sum[WIDTH];
         res_id_d    = sel;
         rr_ptr_d    = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
      end else if (res_ready) begin
         // Consumed with nothing new: payload holds its last value.
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_carry_q <= res_carry_d;
         res_id_q    <= res_id_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_carry = res_carry_q;
   assign res_id    = res_id_q;

endmodule

`default_nettype wire

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit adder among NREQ requesters. It accepts one operand pair per cycle through a valid/ready handshake and registers the sum with a carry flag and the source ID. The result leaves through a single output channel that can be back-pressured. It sits between the pin-level input muxing and the output drivers of the demo top, replacing direct per-pin adders.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 8: operand and result width.
- IDW, $clog2(NREQ): width of the requester ID.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- req_valid  in  NREQ: request i presents an operand pair.
- req_a  in  NREQ*WIDTH: operand A; requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH: operand B; same packing as req_a.
- req_ready  out  NREQ: one-hot grant; transfer on req_valid[i] & req_ready[i].
- res_valid  out  1: result register holds an unconsumed result.
- res_ready  in  1: consumer accepts the result this cycle.
- res_data  out  WIDTH: sum (see Configuration).
- res_carry  out  1: carry-out / overflow of the addition.
- res_id  out  IDW: index of the requester that produced res_data.

## Operation
- Output register has two states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- can_accept = !res_valid | res_ready.
- Grant is combinational:
  - When can_accept is 1 and any req_valid is set, assert exactly one req_ready bit: the first valid index found scanning from rr_ptr upward, wrapping modulo NREQ.
  - Otherwise req_ready = 0.
  - req_ready[i] is never asserted while req_valid[i] = 0.
- On a transfer from requester g:
  - {res_carry, sum} <= req_a[g] + req_b[g], computed at WIDTH+1 bits.
  - res_id <= g; res_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ.
- Consume without a new transfer: res_valid <= 0. res_data, res_carry and res_id hold their last values.
- Consume and transfer in the same cycle: the new result replaces the old one, res_valid stays 1, and there is no bubble.
- FULL with res_ready = 0: all req_ready = 0, and the result is held stable.
- rr_ptr changes only on a transfer.
- A requester must hold req_valid and its operands stable until accepted. The arbiter does not latch unaccepted requests.
- Reset values (async assert, synchronous release):
  - res_valid = 0, res_data = 0, res_carry = 0, res_id = 0.
  - rr_ptr = 0.
  - req_ready = 0 while rst is high.

## Timing
- Latency: operands transferred at edge N appear on res_* after edge N; res_valid is high in cycle N+1.
- Throughput: one result per cycle while res_ready is held high.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0, and no requester waits more than NREQ-1 grants.
- Combinational paths:
  - req_valid → req_ready.
  - res_ready → req_ready.
  - There is no path from any input to res_*.
- Reset asserted mid-operation: any pending result is dropped in the same cycle (res_valid → 0 asynchronously), and rr_ptr returns to 0.

## Configuration
- ADDER_SAT_EN defined:
  - If the WIDTH+1-bit sum exceeds 2^WIDTH-1, res_data = all ones (saturate).
  - res_carry = 1 flags the overflow.
- ADDER_SAT_EN undefined:
  - res_data = low WIDTH bits of the sum (wrap-around).
  - res_carry = the carry-out bit.
- No other behaviour differs between the two builds.

## Test plan
- Reset then idle: rst pulse, all req_valid = 0 → res_valid = 0, res_data = 0, res_id = 0, req_ready = 0 for 10 cycles.
- Single request: requester 2 with a = 0x12, b = 0x34, res_ready = 1 → req_ready = 0b0100 for one cycle. Next cycle res_valid = 1, res_data = 0x46, res_carry = 0, res_id = 2.
- Round-robin: all four requesters valid continuously with res_ready = 1 → grant order 0,1,2,3,0,1 on consecutive cycles, and one result per cycle.
- Back-pressure: result FULL and res_ready = 0 for 5 cycles with requesters valid → req_ready = 0 and res_* stable. res_ready rising → same-cycle grant to the next requester in RR order, with no bubble.
- Overflow: a = 0xF0, b = 0x20.
  - Without ADDER_SAT_EN: res_data = 0x10, res_carry = 1.
  - With ADDER_SAT_EN: res_data = 0xFF, res_carry = 1.
- Reset mid-operation: rst asserted while res_valid = 1 and rr_ptr = 3 → res_valid drops immediately. After release, with all requesters valid, the first grant goes to requester 0.
